// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
//   arb_state_e : arbiter FSM states
//   CNT_W       : width of the access-latency down-counter
//   WORD_W      : address / data word width
package mem_arb_pkg;

    localparam int CNT_W  = 4;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arb_state_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times one memory access.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, clears the count
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value loaded at grant (LATENCY-1)
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero (last busy cycle)
module mem_latency_counter
    import mem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported, fixed-latency unified memory shared by the
// fetch (I) and memory (D) pipeline stages. Data wins simultaneous requests.
// A granted access always runs to completion and ends with a one-cycle
// Ready pulse carrying the registered read word.
//   CLK, RST_N                 : clock, asynchronous active-low reset
//   IReq/IAddr -> IRD/IReady   : fetch port
//   DReq/DWE/DAddr/DWD -> DRD/DReady : data port
//   StallF, StallM             : request pending and not completing this cycle
//   MemA/MemWD/MemWE <- MemRD  : external memory side
// LATENCY (memory cycles per access) must lie in 1..15.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IReq,
    input  logic [WORD_W-1:0] IAddr,
    output logic [WORD_W-1:0] IRD,
    output logic              IReady,
    input  logic              DReq,
    input  logic              DWE,
    input  logic [WORD_W-1:0] DAddr,
    input  logic [WORD_W-1:0] DWD,
    output logic [WORD_W-1:0] DRD,
    output logic              DReady,
    output logic              StallF,
    output logic              StallM,
    output logic [WORD_W-1:0] MemA,
    output logic [WORD_W-1:0] MemWD,
    output logic              MemWE,
    input  logic [WORD_W-1:0] MemRD
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    arb_state_e state_q, state_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wd_q, wd_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] ird_q, ird_d;
    logic [WORD_W-1:0] drd_q, drd_d;
    logic              iready_q, iready_d;
    logic              dready_q, dready_d;

    mem_latency_counter u_cnt (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        addr_d   = addr_q;
        wd_d     = wd_q;
        we_d     = we_q;
        ird_d    = ird_q;
        drd_d    = drd_q;
        iready_d = 1'b0;
        dready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (DReq) begin
                    state_d  = BUSY_D;
                    cnt_load = 1'b1;
                    addr_d   = DAddr;
                    wd_d     = DWD;
                    we_d     = DWE;
                end else if (IReq) begin
                    // Write data is left untouched so MemWD keeps its last value.
                    state_d  = BUSY_I;
                    cnt_load = 1'b1;
                    addr_d   = IAddr;
                    we_d     = 1'b0;
                end
            end
            BUSY_I: begin
                if (cnt_zero) begin
                    state_d  = DONE_I;
                    ird_d    = MemRD;
                    iready_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            BUSY_D: begin
                if (cnt_zero) begin
                    state_d  = DONE_D;
                    drd_d    = MemRD;
                    dready_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            // The requester may still be high here; returning to IDLE first
            // prevents the same request from being granted twice.
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            ird_q    <= '0;
            drd_q    <= '0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            ird_q    <= ird_d;
            drd_q    <= drd_d;
            iready_q <= iready_d;
            dready_q <= dready_d;
        end
    end

    // Single write pulse: only on the last busy cycle of a store.
    assign MemWE  = (state_q == BUSY_D) && we_q && cnt_zero;
    assign MemA   = addr_q;
    assign MemWD  = wd_q;
    assign IRD    = ird_q;
    assign DRD    = drd_q;
    assign IReady = iready_q;
    assign DReady = dready_q;
    assign StallF = IReq & ~iready_q;
    assign StallM = DReq & ~dready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with LATENCY 1..4, each with its own
// memory model, checked every cycle against a transaction-age reference.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int MW = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        ireq   [N];
    logic        dreq   [N];
    logic        dwe    [N];
    logic [31:0] iaddr  [N];
    logic [31:0] daddr  [N];
    logic [31:0] dwd    [N];
    logic [31:0] memrd  [N];
    logic [31:0] ird    [N];
    logic [31:0] drd    [N];
    logic [31:0] mema   [N];
    logic [31:0] memwd  [N];
    logic        iready [N];
    logic        dready [N];
    logic        stallf [N];
    logic        stallm [N];
    logic        memwe  [N];

    bit [31:0] mem    [N][MW];
    bit        mem_v  [N][MW];
    int        obs_wr [N];

    // reference model state
    int          m_gnt  [N];   // 0 none, 1 fetch, 2 data
    int          m_age  [N];   // cycles since grant (1..LAT busy, LAT+1 done)
    int          m_wr   [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd   [N];
    logic [31:0] m_ird  [N];
    logic [31:0] m_drd  [N];
    bit          m_we   [N];
    bit [31:0]   r_mem  [N][MW];
    bit          r_v    [N][MW];

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        e_iready;
        logic        e_dready;
        logic        e_stallf;
        logic        e_stallm;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2008_0005;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter #(.LATENCY(g + 1)) u_dut (
            .CLK    (clk),
            .RST_N  (rst_n),
            .IReq   (ireq[g]),
            .IAddr  (iaddr[g]),
            .IRD    (ird[g]),
            .IReady (iready[g]),
            .DReq   (dreq[g]),
            .DWE    (dwe[g]),
            .DAddr  (daddr[g]),
            .DWD    (dwd[g]),
            .DRD    (drd[g]),
            .DReady (dready[g]),
            .StallF (stallf[g]),
            .StallM (stallm[g]),
            .MemA   (mema[g]),
            .MemWD  (memwd[g]),
            .MemWE  (memwe[g]),
            .MemRD  (memrd[g])
        );
        assign memrd[g] = mem_v[g][mema[g][11:2]] ? mem[g][mema[g][11:2]]
                                                  : init_word({mema[g][31:2], 2'b00});
    end

    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (memwe[g] === 1'b1) begin
                mem[g][mema[g][11:2]]   <= memwd[g];
                mem_v[g][mema[g][11:2]] <= 1'b1;
                obs_wr[g]               <= obs_wr[g] + 1;
            end
        end
    end

    function automatic logic [31:0] ref_read(input int k, input logic [31:0] a);
        return r_v[k][a[11:2]] ? r_mem[k][a[11:2]] : init_word({a[31:2], 2'b00});
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d (LATENCY=%0d): got %h expected %h", nm, k, k + 1, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_gnt[k]  = 0;
            m_age[k]  = 0;
            m_addr[k] = '0;
            m_wd[k]   = '0;
            m_we[k]   = 1'b0;
            m_ird[k]  = '0;
            m_drd[k]  = '0;
        end
    endtask

    task automatic model_edge(input int k);
        int lat = k + 1;
        logic [31:0] w;
        if (m_gnt[k] == 0) begin
            if (dreq[k]) begin
                m_gnt[k]  = 2;
                m_age[k]  = 1;
                m_addr[k] = daddr[k];
                m_wd[k]   = dwd[k];
                m_we[k]   = dwe[k];
            end else if (ireq[k]) begin
                m_gnt[k]  = 1;
                m_age[k]  = 1;
                m_addr[k] = iaddr[k];
            end
        end else if (m_age[k] == lat + 1) begin
            m_gnt[k] = 0;
            m_age[k] = 0;
        end else begin
            if (m_age[k] == lat) begin
                w = ref_read(k, m_addr[k]);
                if (m_gnt[k] == 1) begin
                    m_ird[k] = w;
                end else begin
                    m_drd[k] = w;
                    if (m_we[k]) begin
                        r_mem[k][m_addr[k][11:2]] = m_wd[k];
                        r_v[k][m_addr[k][11:2]]   = 1'b1;
                        m_wr[k]++;
                    end
                end
            end
            m_age[k]++;
        end
    endtask

    task automatic check_dut(input int k);
        logic e_ir, e_dr, e_we;
        e_ir = (m_gnt[k] == 1) && (m_age[k] == k + 2);
        e_dr = (m_gnt[k] == 2) && (m_age[k] == k + 2);
        e_we = (m_gnt[k] == 2) && m_we[k] && (m_age[k] == k + 1);
        chk("IReady", k, iready[k], e_ir);
        chk("DReady", k, dready[k], e_dr);
        chk("IRD",    k, ird[k],    m_ird[k]);
        chk("DRD",    k, drd[k],    m_drd[k]);
        chk("MemA",   k, mema[k],   m_addr[k]);
        chk("MemWD",  k, memwd[k],  m_wd[k]);
        chk("MemWE",  k, memwe[k],  e_we);
        chk("StallF", k, stallf[k], ireq[k] & ~e_ir);
        chk("StallM", k, stallm[k], dreq[k] & ~e_dr);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < N; k++) model_edge(k);
        end
        #1;
        for (int k = 0; k < N; k++) check_dut(k);
    endtask

    task automatic set_all(input logic ir, input logic dr, input logic we,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        for (int k = 0; k < N; k++) begin
            ireq[k]  = ir;
            dreq[k]  = dr;
            dwe[k]   = we;
            iaddr[k] = ia;
            daddr[k] = da;
            dwd[k]   = wd;
        end
    endtask

    task automatic idle_all(input int n);
        for (int k = 0; k < N; k++) begin
            ireq[k] = 1'b0;
            dreq[k] = 1'b0;
        end
        repeat (n) step();
    endtask

    initial begin
        int w0;
        int n_st;
        int cyc;
        bit got;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'hDEAD_BEEF};

        set_all(1'b0, 1'b0, 1'b0, '0, '0, '0);
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check_dut(k);
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous D load / I fetch, then a lone fetch (LATENCY=2 instance).
        for (int i = 0; i < 12; i++) begin
            set_all(tbl[i].ireq, tbl[i].dreq, tbl[i].dwe, tbl[i].iaddr, tbl[i].daddr, tbl[i].dwd);
            if (i == 8) begin
                #1;
                chk("tbl_StallF_c0", 1, stallf[1], 1'b1);
            end
            step();
            chk("tbl_IReady", 1, iready[1], tbl[i].e_iready);
            chk("tbl_DReady", 1, dready[1], tbl[i].e_dready);
            chk("tbl_StallF", 1, stallf[1], tbl[i].e_stallf);
            chk("tbl_StallM", 1, stallm[1], tbl[i].e_stallm);
            chk("tbl_IRD",    1, ird[1],    tbl[i].e_ird);
            chk("tbl_DRD",    1, drd[1],    tbl[i].e_drd);
        end
        idle_all(8);

        // Store at LATENCY=3: write pulse in cycle 3 only, DReady in cycle 4.
        set_all(1'b0, 1'b1, 1'b1, '0, 32'h200, 32'h1234_5678);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("st_MemWE", 2, memwe[2], (c == 3));
            if (c == 3) begin
                chk("st_MemA",  2, mema[2],  32'h200);
                chk("st_MemWD", 2, memwd[2], 32'h1234_5678);
            end
            chk("st_DReady", 2, dready[2], (c == 4));
            if (c == 4) begin
                for (int k = 0; k < N; k++) dreq[k] = 1'b0;
            end
        end
        idle_all(8);

        // Request dropped in cycle 1 of a LATENCY=4 store: access still completes.
        w0 = obs_wr[3];
        set_all(1'b0, 1'b1, 1'b1, '0, 32'h280, 32'hA5A5_5A5A);
        step();
        for (int k = 0; k < N; k++) dreq[k] = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            step();
            chk("fl_MemWE",  3, memwe[3],  (c == 4));
            chk("fl_DReady", 3, dready[3], (c == 5));
        end
        chk("fl_writes", 3, obs_wr[3] - w0, 1);
        idle_all(4);

        // Reset during the write cycle of a LATENCY=3 store.
        set_all(1'b0, 1'b1, 1'b1, '0, 32'h300, 32'hCAFE_F00D);
        repeat (3) step();
        chk("rs_MemWE_pre", 2, memwe[2], 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rs_MemWE",  2, memwe[2],  1'b0);
        chk("rs_IReady", 2, iready[2], 1'b0);
        chk("rs_DReady", 2, dready[2], 1'b0);
        chk("rs_MemA",   2, mema[2],   32'h0);
        for (int k = 0; k < N; k++) check_dut(k);
        set_all(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs_mem2", 2, mem_v[2][10'h0C0], 1'b0);
        chk("rs_mem3", 3, mem_v[3][10'h0C0], 1'b0);
        idle_all(2);

        // LATENCY=1: 20 alternating I/D accesses, 3 cycles each.
        w0   = obs_wr[0];
        n_st = 0;
        for (int a = 0; a < 20; a++) begin
            if (a[0]) begin
                dreq[0]  = 1'b1;
                dwe[0]   = 1'($urandom_range(1));
                daddr[0] = {22'h0, 8'($urandom_range(63)), 2'b00};
                dwd[0]   = $urandom;
                if (dwe[0]) n_st++;
            end else begin
                ireq[0]  = 1'b1;
                iaddr[0] = {22'h0, 8'($urandom_range(63)), 2'b00};
            end
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 8) begin
                step();
                cyc++;
                chk("alt_double", 0, iready[0] & dready[0], 1'b0);
                if (iready[0] === 1'b1 || dready[0] === 1'b1) begin
                    got = 1'b1;
                    chk("alt_port", 0, dready[0], a[0]);
                end
            end
            chk("alt_latency", 0, cyc, 2);
            ireq[0] = 1'b0;
            dreq[0] = 1'b0;
            step();
            chk("alt_idle", 0, iready[0] | dready[0], 1'b0);
        end
        chk("alt_writes", 0, obs_wr[0] - w0, n_st);

        // Random requesters on every instance, checked by the reference model.
        for (int t = 0; t < 2500; t++) begin
            for (int k = 0; k < N; k++) begin
                if (ireq[k] && iready[k]) begin
                    ireq[k] = 1'b0;
                end else if (!ireq[k] && $urandom_range(3) == 0) begin
                    ireq[k]  = 1'b1;
                    iaddr[k] = {22'h0, 8'($urandom_range(63)), 2'b00};
                end
                if (dreq[k] && dready[k]) begin
                    dreq[k] = 1'b0;
                end else if (dreq[k] && $urandom_range(15) == 0) begin
                    dreq[k] = 1'b0;
                end else if (!dreq[k] && $urandom_range(2) == 0) begin
                    dreq[k]  = 1'b1;
                    dwe[k]   = 1'($urandom_range(1));
                    daddr[k] = {22'h0, 8'($urandom_range(63)), 2'b00};
                    dwd[k]   = $urandom;
                end
            end
            step();
        end
        idle_all(20);
        for (int k = 0; k < N; k++) chk("rnd_writes", k, obs_wr[k], m_wr[k]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
